// File: rtl/axil_regbank.sv
// AXI-Lite slave register bank: ID, scratch, cycle counter, control, W1C status
// and NGP general-purpose registers. One outstanding write and one outstanding read.
module axil_regbank #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h7C1E_0001,
    parameter int          NGP        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           ctrl_out,
    input  logic [31:0]           status_set
);
    localparam int IW = ADDR_WIDTH - 2;

    logic                  aw_lat, w_lat;
    logic [IW-1:0]         aw_idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           scratch, cycle, ctrl, status;
    logic [NGP-1:0][31:0]  gp;

    logic [IW-1:0]         rd_idx;
    logic [31:0]           rd_val;
    logic                  rd_err;
    logic                  wr_go, wr_err;
    logic [31:0]           wmask, st_clr;

    // Byte-lane offsets are ignored by the decode.
    logic unused_lsbs;
    assign unused_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign s_axi_awready = !aw_lat && !s_axi_bvalid;
    assign s_axi_wready  = !w_lat  && !s_axi_bvalid;
    assign s_axi_arready = !s_axi_rvalid;
    assign ctrl_out      = ctrl;

    assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:2];
    assign wr_go  = aw_lat && w_lat;
    assign wr_err = aw_idx_q >= IW'(5 + NGP);

    always_comb begin
        for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{wstrb_q[i]}};
    end

    assign st_clr = (wr_go && aw_idx_q == IW'(4)) ? (wdata_q & wmask) : 32'h0;

    always_comb begin
        rd_val = 32'h0;
        rd_err = 1'b0;
        if      (rd_idx == IW'(0)) rd_val = ID_VALUE;
        else if (rd_idx == IW'(1)) rd_val = scratch;
        else if (rd_idx == IW'(2)) rd_val = cycle;
        else if (rd_idx == IW'(3)) rd_val = ctrl;
        else if (rd_idx == IW'(4)) rd_val = status;
        else if (rd_idx < IW'(5 + NGP)) begin
            for (int i = 0; i < NGP; i++)
                if (rd_idx == IW'(5 + i)) rd_val = gp[i];
        end else
            rd_err = 1'b1;
    end

    // Channel handshakes; the commit cycle blocks new AW/W since both readies are low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_lat       <= 1'b0;
            w_lat        <= 1'b0;
            aw_idx_q     <= '0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= 2'b00;
            s_axi_rdata  <= 32'h0;
        end else begin
            if (wr_go) begin
                aw_lat       <= 1'b0;
                w_lat        <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
            end else begin
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_lat   <= 1'b1;
                    aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
                end
                if (s_axi_wvalid && s_axi_wready) begin
                    w_lat   <= 1'b1;
                    wdata_q <= s_axi_wdata;
                    wstrb_q <= s_axi_wstrb;
                end
            end
            if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;

            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Register file; status_set wins over a simultaneous W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch <= 32'h0;
            cycle   <= 32'h0;
            ctrl    <= 32'h0;
            status  <= 32'h0;
            gp      <= '0;
        end else begin
            cycle  <= cycle + 32'h1;
            status <= (status & ~st_clr) | status_set;
            if (wr_go && aw_idx_q == IW'(1)) scratch <= merge(scratch, wdata_q, wmask);
            if (wr_go && aw_idx_q == IW'(3)) ctrl    <= merge(ctrl, wdata_q, wmask);
            for (int i = 0; i < NGP; i++)
                if (wr_go && aw_idx_q == IW'(5 + i)) gp[i] <= merge(gp[i], wdata_q, wmask);
        end
    end
endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank: handshake timing, strobes, W1C, decode errors, reset.
module tb_axil_regbank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, status_set = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ctrl_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd, c0, c1;
    logic [1:0]  rs;

    axil_regbank dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ctrl_out(ctrl_out), .status_set(status_set)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  n = 0;
        logic aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while ((awvalid || wvalid) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) awvalid = 0;
            if (w_hs)  wvalid  = 0;
            n++;
        end
        while (!bvalid && n < 50) begin step(); n++; end
        resp = bresp;
        step();
        bready = 0; awvalid = 0; wvalid = 0;
        chk("wr_timeout", 32'(n >= 50), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1; rready = 1;
        while (!arready && n < 50) begin step(); n++; end
        step();
        arvalid = 0;
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        d = rdata; resp = rresp;
        step();
        rready = 0;
        chk("rd_timeout", 32'(n >= 50), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_awready", 32'(awready), 1); chk("rst_wready", 32'(wready), 1);
        chk("rst_arready", 32'(arready), 1); chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);   chk("rst_bresp", 32'(bresp), 0);
        chk("rst_rdata", rdata, 0);          chk("rst_ctrl", ctrl_out, 0);
        step(); rst = 0;

        // AW and W in the same cycle to SCRATCH
        awaddr = 32'h04; wdata = 32'hA5A5_5A5A; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step(); awvalid = 0; wvalid = 0;
        chk("same_bvalid_early", 32'(bvalid), 0); chk("same_awready_lo", 32'(awready), 0);
        step();
        chk("same_bvalid", 32'(bvalid), 1); chk("same_bresp", 32'(bresp), 0);
        bready = 1; step(); bready = 0;
        chk("same_post_b_bvalid", 32'(bvalid), 0); chk("same_post_b_awready", 32'(awready), 1);
        axi_read(32'h04, rd, rs);
        chk("scratch_rd", rd, 32'hA5A5_5A5A); chk("scratch_rresp", 32'(rs), 0);

        // W three cycles before AW to CTRL, low two bytes only
        awaddr = 32'h0C; wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1;
        step(); wvalid = 0;
        step(); step();
        chk("wfirst_wready_lo", 32'(wready), 0); chk("wfirst_bvalid_lo", 32'(bvalid), 0);
        chk("wfirst_awready_hi", 32'(awready), 1);
        awvalid = 1; step(); awvalid = 0;
        chk("wfirst_ctrl_pre", ctrl_out, 0);
        step();
        chk("wfirst_bvalid", 32'(bvalid), 1); chk("wfirst_ctrl", ctrl_out, 32'h0000_5678);
        bready = 1; step(); bready = 0;

        // bready held low for 5 cycles; second AW/W waits
        awaddr = 32'h14; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step(); awvalid = 0; wvalid = 0;
        step();
        awaddr = 32'h18; wdata = 32'h0000_1111; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bhold_bvalid", 32'(bvalid), 1);   chk("bhold_bresp", 32'(bresp), 0);
            chk("bhold_awready", 32'(awready), 0); chk("bhold_wready", 32'(wready), 0);
        end
        bready = 1; step(); bready = 0;
        chk("bhold_released", 32'(bvalid), 0); chk("bhold_awready_back", 32'(awready), 1);
        step(); awvalid = 0; wvalid = 0;
        chk("second_aw_latched", 32'(awready), 0);
        step();
        chk("second_bvalid", 32'(bvalid), 1);
        bready = 1; step(); bready = 0;
        axi_read(32'h14, rd, rs); chk("gp0_rd", rd, 32'hDEAD_BEEF);
        axi_read(32'h18, rd, rs); chk("gp1_rd", rd, 32'h0000_1111);

        // Unmapped address
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, rs); chk("unmap_bresp", 32'(rs), 32'h2);
        axi_read(32'h40, rd, rs);
        chk("unmap_rresp", 32'(rs), 32'h2); chk("unmap_rdata", rd, 0);
        axi_read(32'h04, rd, rs); chk("unmap_scratch_kept", rd, 32'hA5A5_5A5A);
        axi_read(32'h14, rd, rs); chk("unmap_gp0_kept", rd, 32'hDEAD_BEEF);
        chk("unmap_ctrl_kept", ctrl_out, 32'h0000_5678);
        axi_write(32'h00, 32'h0, 4'hF, rs); chk("ro_bresp", 32'(rs), 0);
        axi_read(32'h00, rd, rs); chk("id_rd", rd, 32'h7C1E_0001);

        // STATUS: set wins over simultaneous W1C
        status_set = 32'h3; step(); status_set = 32'h0;
        awaddr = 32'h10; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step(); awvalid = 0; wvalid = 0; status_set = 32'h1;
        step(); status_set = 32'h0;
        chk("st_bvalid", 32'(bvalid), 1);
        bready = 1; step(); bready = 0;
        axi_read(32'h10, rd, rs); chk("st_set_wins", rd, 32'h3);
        axi_write(32'h10, 32'h1, 4'hF, rs);
        axi_read(32'h10, rd, rs); chk("st_w1c", rd, 32'h2);
        axi_write(32'h10, 32'h2, 4'h0, rs);
        axi_read(32'h10, rd, rs); chk("st_nostrb", rd, 32'h2);

        // CYCLE reads 10 edges apart
        axi_read(32'h08, c0, rs);
        repeat (8) @(posedge clk);
        #1;
        axi_read(32'h08, c1, rs);
        chk("cycle_diff", c1 - c0, 32'd10);

        // Reset in the middle of a read
        araddr = 32'h04; arvalid = 1; rready = 0;
        step(); arvalid = 0;
        chk("mid_rvalid", 32'(rvalid), 1); chk("mid_arready", 32'(arready), 0);
        rst = 1; #1;
        chk("mid_rst_rvalid", 32'(rvalid), 0); chk("mid_rst_arready", 32'(arready), 1);
        chk("mid_rst_rdata", rdata, 0);        chk("mid_rst_ctrl", ctrl_out, 0);
        step(); rst = 0;
        axi_read(32'h04, rd, rs); chk("post_rst_scratch", rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axil_regbank.md
Name: axil_regbank

Overview:
- AXI-Lite slave register bank on the downstream side of the AL-to-AXI-Lite bridge; consumes the bridge's s_axi_* master channels.
- Provides ID, scratch, cycle counter, control, W1C status and general-purpose registers to the PCIe-side control plane.
- One outstanding write and one outstanding read; independent AW/W acceptance; SLVERR on unmapped addresses.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
ID_VALUE, 32'h7C1E_0001, value returned by the ID register
NGP, 4, number of general-purpose RW registers (1..16)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
s_axi_awaddr  input  ADDR_WIDTH  write address (byte)
s_axi_awvalid  input  1  write address valid
s_axi_awready  output  1  write address ready
s_axi_wdata  input  32  write data
s_axi_wstrb  input  4  byte strobes
s_axi_wvalid  input  1  write data valid
s_axi_wready  output  1  write data ready
s_axi_bresp  output  2  write response (00 OKAY, 10 SLVERR)
s_axi_bvalid  output  1  write response valid
s_axi_bready  input  1  write response ready
s_axi_araddr  input  ADDR_WIDTH  read address (byte)
s_axi_arvalid  input  1  read address valid
s_axi_arready  output  1  read address ready
s_axi_rdata  output  32  read data
s_axi_rresp  output  2  read response
s_axi_rvalid  output  1  read data valid
s_axi_rready  input  1  read data ready
ctrl_out  output  32  current CTRL register value
status_set  input  32  per-bit set pulses into STATUS

Behaviour:
- Reset: one clock; reset asynchronous, active-high (clk, rst). On rst: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, SCRATCH=0, CTRL=0 (ctrl_out=0), STATUS=0, counter=0, GP regs=0; latched AW/W flags cleared. Reset mid-transaction drops it, no response issued.
- Decode: word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. 0 ID (RO), 1 SCRATCH (RW), 2 CYCLE (RO), 3 CTRL (RW), 4 STATUS (W1C), 5..4+NGP GP (RW). Any other index unmapped.
- Write channel: awready high iff no AW latched and bvalid=0; wready high iff no W latched and bvalid=0. AW and W accepted independently in any order or cycle; each latched on its handshake, then its ready drops.
- Commit: in the cycle both AW and W are latched (including both accepted at the same edge N), the write is applied at edge N+1 and bvalid=1 from edge N+1; latches cleared at the same edge.
- Strobes: RW registers update only bytes with wstrb[i]=1; STATUS clears bits where wdata=1 within strobed bytes; RO/unmapped writes have no effect. bresp=10 for unmapped, 00 otherwise (including RO writes).
- bvalid holds with bresp stable until bready; after the bready handshake edge awready/wready return high the next cycle.
- Read channel: arready high iff rvalid=0. Handshake at edge N captures rdata/rresp from register values before edge N updates; rvalid=1 from edge N. Held stable until rready handshake; rvalid then drops and arready rises the same edge. Unmapped: rdata=0, rresp=10.
- CYCLE: 32-bit free-running, +1 every clk, wraps FFFF_FFFF->0.
- STATUS: bit set when status_set bit is 1; set wins over a W1C clear in the same cycle.
- Read and write to the same register on the same edge: read returns the old value.

Test Plan:
- AW and W same cycle to 0x04, data A5A5_5A5A, strb F -> bvalid next cycle, bresp 00; read 0x04 -> A5A5_5A5A, rresp 00.
- W three cycles before AW to 0x0C, strb 0011, data 1234_5678 over CTRL=0 -> wready low during the wait; ctrl_out=0000_5678 after commit.
- Hold bready=0 for 5 cycles after a write -> bvalid and bresp stable, awready/wready stay 0; second AW not accepted until handshake.
- Write 0x40 (unmapped, NGP=4) and read 0x40 -> bresp 10; rresp 10, rdata 0; no register changes.
- Pulse status_set=0000_0003; write 0x10 data 0000_0001 while status_set bit0 pulses again -> STATUS reads 0000_0003; clean W1C then reads 0000_0002.
- Read 0x00 -> ID_VALUE; read 0x08 twice, 10 cycles apart with rready=1 -> difference 10; assert rst mid-read -> rvalid 0, arready 1 immediately.
